// File: rtl/lif_scheduler.sv
// ============================================================================
// Module      : lif_scheduler
// Description : Time-multiplexed leaky integrate-and-fire neuron scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lif_scheduler #(
    parameter int N_NEURONS = 8,
    parameter int VW        = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_addr,
    input  logic [7:0]                   cfg_data,
    input  logic                         in_valid,
    input  logic [$clog2(N_NEURONS)-1:0] in_idx,
    input  logic [VW-1:0]                in_weight,
    output logic                         in_ready,
    input  logic                         step,
    output logic                         busy,
    output logic [N_NEURONS-1:0]         spikes,
    output logic                         spike_valid
);

    localparam int c_IW = $clog2(N_NEURONS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [c_IW-1:0]        cnt_q, cnt_d;

    logic [VW-1:0]          thr_q, thr_w_q;
    logic [2:0]             leak_q, leak_w_q;
    logic [3:0]             refp_q, refp_w_q;
    logic                   en_q;

    logic [VW-1:0]          v_q   [N_NEURONS];
    logic [VW-1:0]          acc_q [N_NEURONS];
    logic [3:0]             ref_q [N_NEURONS];
    logic [N_NEURONS-1:0]   spk_work_q;
    logic [N_NEURONS-1:0]   spikes_q;

    logic                   w_start, w_accept, w_last, w_fire;
    logic [VW-1:0]          w_v_cur, w_leak_term, w_v_sat, w_v_new, w_acc_sat;
    logic [VW:0]            w_v_sum, w_acc_sum;
    logic [3:0]             w_ref_cur, w_ref_new;
    logic [N_NEURONS-1:0]   w_spk_next;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        in_ready    = 1'b0;
        busy        = 1'b1;
        spike_valid = 1'b0;
        w_start     = 1'b0;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (step && en_q) begin
                    w_start = 1'b1;
                    cnt_d   = '0;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                cnt_d = cnt_q + 1'b1;
                if (w_last) state_d = S_DONE;
            end
            S_DONE: begin
                spike_valid = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    assign w_accept = in_valid && in_ready;
    assign w_last   = (cnt_q == c_IW'(N_NEURONS - 1));

    // Neuron update for the currently scheduled index; sums carry one guard bit.
    always_comb begin
        w_v_cur     = v_q[cnt_q];
        w_ref_cur   = ref_q[cnt_q];
        w_leak_term = (leak_w_q == 3'd0) ? '0 : (w_v_cur >> leak_w_q);
        w_v_sum     = {1'b0, w_v_cur} - {1'b0, w_leak_term} + {1'b0, acc_q[cnt_q]};
        w_v_sat     = w_v_sum[VW] ? '1 : w_v_sum[VW-1:0];
        w_fire      = (w_ref_cur == 4'd0) && (w_v_sat >= thr_w_q);
        w_v_new     = ((w_ref_cur != 4'd0) || w_fire) ? '0 : w_v_sat;
        if (w_ref_cur != 4'd0) w_ref_new = w_ref_cur - 4'd1;
        else if (w_fire)       w_ref_new = refp_w_q;
        else                   w_ref_new = 4'd0;
        w_spk_next        = spk_work_q;
        w_spk_next[cnt_q] = w_fire;
        w_acc_sum         = {1'b0, acc_q[in_idx]} + {1'b0, in_weight};
        w_acc_sat         = w_acc_sum[VW] ? '1 : w_acc_sum[VW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            thr_q      <= VW'(8'h80);
            leak_q     <= 3'd0;
            refp_q     <= 4'd0;
            en_q       <= 1'b0;
            thr_w_q    <= VW'(8'h80);
            leak_w_q   <= 3'd0;
            refp_w_q   <= 4'd0;
            spk_work_q <= '0;
            spikes_q   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i]   <= '0;
                acc_q[i] <= '0;
                ref_q[i] <= 4'd0;
            end
        end else begin
            cnt_q <= cnt_d;
            if (cfg_we) begin
                case (cfg_addr)
                    2'd0:    thr_q  <= VW'(cfg_data);
                    2'd1:    leak_q <= cfg_data[2:0];
                    2'd2:    refp_q <= cfg_data[3:0];
                    default: en_q   <= cfg_data[0];
                endcase
            end
            // Working copies freeze the configuration for the whole timestep.
            if (w_start) begin
                thr_w_q  <= thr_q;
                leak_w_q <= leak_q;
                refp_w_q <= refp_q;
            end
            if (w_accept) acc_q[in_idx] <= w_acc_sat;
            if (state_q == S_UPDATE) begin
                v_q[cnt_q]   <= w_v_new;
                ref_q[cnt_q] <= w_ref_new;
                acc_q[cnt_q] <= '0;
                spk_work_q   <= w_spk_next;
                if (w_last) spikes_q <= w_spk_next;
            end
        end
    end

    assign spikes = spikes_q;

endmodule

`default_nettype wire

// File: tb/tb_lif_scheduler.sv
// ============================================================================
// Module      : tb_lif_scheduler
// Description : Directed vector bench for lif_scheduler (N_NEURONS=8, VW=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lif_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = 2'd0;
    logic [7:0] cfg_data = 8'd0;
    logic       in_valid = 1'b0;
    logic [2:0] in_idx = 3'd0;
    logic [7:0] in_weight = 8'd0;
    logic       in_ready;
    logic       step = 1'b0;
    logic       busy;
    logic [7:0] spikes;
    logic       spike_valid;

    int n_vec = 0;
    int n_err = 0;

    lif_scheduler #(.N_NEURONS(8), .VW(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .in_valid(in_valid), .in_idx(in_idx),
        .in_weight(in_weight), .in_ready(in_ready), .step(step), .busy(busy),
        .spikes(spikes), .spike_valid(spike_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [7:0] thr;
        logic [2:0] leak;
        logic [3:0] refp;
        int         nev;
        logic [2:0] i0;
        logic [7:0] w0;
        logic [2:0] i1;
        logic [7:0] w1;
        logic [7:0] exp_spk;
        bit         chk_v;
        logic [2:0] vi;
        logic [7:0] exp_v;
    } vec_t;

    vec_t vt [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // Called with step already driven; returns one cycle after the DONE cycle.
    task automatic wait_done(input string name, input logic [7:0] exp_spk);
        int lat;
        lat = -1;
        @(negedge clk);
        step = 1'b0; in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (spike_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            check({name, "_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, "_latency"}, lat, 8);
            check({name, "_spikes"}, spikes, exp_spk);
            @(negedge clk);
        end
    endtask

    initial begin
        //           rst thr  lk rf nev i0 w0  i1 w1  spk    cv vi expv
        vt[0]  = '{1, 100, 0, 0, 1, 3, 60,  0, 0,  8'h00, 1, 3, 60};
        vt[1]  = '{0, 100, 0, 0, 1, 3, 60,  0, 0,  8'h08, 1, 3, 0};
        vt[2]  = '{1, 255, 1, 0, 1, 0, 200, 0, 0,  8'h00, 1, 0, 200};
        vt[3]  = '{0, 255, 1, 0, 0, 0, 0,   0, 0,  8'h00, 1, 0, 100};
        vt[4]  = '{0, 255, 1, 0, 0, 0, 0,   0, 0,  8'h00, 1, 0, 50};
        vt[5]  = '{1, 10,  0, 2, 1, 5, 20,  0, 0,  8'h20, 0, 0, 0};
        vt[6]  = '{0, 10,  0, 2, 1, 5, 20,  0, 0,  8'h00, 0, 0, 0};
        vt[7]  = '{0, 10,  0, 2, 1, 5, 20,  0, 0,  8'h00, 0, 0, 0};
        vt[8]  = '{0, 10,  0, 2, 1, 5, 20,  0, 0,  8'h20, 0, 0, 0};
        vt[9]  = '{1, 255, 0, 0, 2, 1, 200, 1, 100, 8'h02, 1, 1, 0};
        vt[10] = '{1, 0,   0, 1, 0, 0, 0,   0, 0,  8'hFF, 0, 0, 0};
        vt[11] = '{0, 0,   0, 1, 0, 0, 0,   0, 0,  8'h00, 0, 0, 0};
        vt[12] = '{0, 0,   0, 1, 0, 0, 0,   0, 0,  8'hFF, 0, 0, 0};
        vt[13] = '{1, 200, 2, 0, 1, 7, 100, 0, 0,  8'h00, 1, 7, 100};
        vt[14] = '{0, 200, 2, 0, 1, 7, 150, 0, 0,  8'h80, 1, 7, 0};
        vt[15] = '{1, 255, 0, 0, 1, 2, 250, 0, 0,  8'h00, 1, 2, 250};
        vt[16] = '{0, 255, 0, 0, 1, 2, 250, 0, 0,  8'h04, 1, 2, 0};
        vt[17] = '{1, 50,  0, 0, 2, 0, 50,  6, 49, 8'h01, 1, 6, 49};

        // Reset state
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_spikes", spikes, 8'h00);
        check("rst_spike_valid", spike_valid, 0);
        do_reset();

        // Step while disabled is ignored
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("dis_busy", busy, 0);
        check("dis_in_ready", in_ready, 1);

        // Table-driven timesteps
        for (int i = 0; i < 18; i++) begin
            if (vt[i].rst) do_reset();
            cfg_wr(2'd0, vt[i].thr);
            cfg_wr(2'd1, {5'd0, vt[i].leak});
            cfg_wr(2'd2, {4'd0, vt[i].refp});
            cfg_wr(2'd3, 8'h01);
            if (vt[i].nev == 2) begin
                in_valid = 1'b1; in_idx = vt[i].i0; in_weight = vt[i].w0;
                @(negedge clk);
                in_idx = vt[i].i1; in_weight = vt[i].w1;
            end else if (vt[i].nev == 1) begin
                in_valid = 1'b1; in_idx = vt[i].i0; in_weight = vt[i].w0;
            end
            step = 1'b1;
            wait_done($sformatf("vec%0d", i), vt[i].exp_spk);
            if (vt[i].chk_v)
                check($sformatf("vec%0d_v", i), dut.v_q[vt[i].vi], vt[i].exp_v);
        end

        // Busy window: second step ignored, events stalled
        do_reset();
        cfg_wr(2'd0, 8'd128);
        cfg_wr(2'd3, 8'h01);
        step = 1'b1;
        in_idx = 3'd0; in_weight = 8'd50;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            check($sformatf("busy_in_ready_t%0d", k), in_ready, (k >= 10));
            check($sformatf("busy_busy_t%0d", k), busy, (k <= 9));
            check($sformatf("busy_sv_t%0d", k), spike_valid, (k == 9));
            step = (k == 3);
            in_valid = (k < 9);
        end
        check("busy_acc0", dut.acc_q[0], 8'd0);

        // Reset in the middle of a timestep
        do_reset();
        cfg_wr(2'd0, 8'd10);
        cfg_wr(2'd3, 8'h01);
        in_valid = 1'b1; in_idx = 3'd2; in_weight = 8'd200;
        step = 1'b1;
        begin
            bit sv_seen;
            sv_seen = 1'b0;
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                step = 1'b0; in_valid = 1'b0;
                if (k == 4) begin
                    rst_n = 1'b0;
                    #1;
                    check("mid_rst_busy", busy, 0);
                    check("mid_rst_in_ready", in_ready, 1);
                    check("mid_rst_spikes", spikes, 8'h00);
                end
                if (k == 6) rst_n = 1'b1;
                if (spike_valid) sv_seen = 1'b1;
            end
            check("mid_rst_no_sv", sv_seen, 0);
        end
        check("mid_rst_v2", dut.v_q[2], 8'd0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        check("mid_rst_enable_cleared", busy, 0);

        // Config written during a timestep only affects the next one
        do_reset();
        cfg_wr(2'd0, 8'd255);
        cfg_wr(2'd3, 8'h01);
        in_valid = 1'b1; in_idx = 3'd4; in_weight = 8'd100;
        step = 1'b1;
        @(negedge clk);
        step = 1'b0; in_valid = 1'b0;
        cfg_wr(2'd0, 8'd50);
        begin
            int lat;
            lat = -1;
            for (int k = 0; k < 40; k++) begin
                if (spike_valid) begin
                    lat = k;
                    break;
                end
                @(negedge clk);
            end
            check("cfg_mid_done", (lat >= 0), 1);
            check("cfg_mid_spikes", spikes, 8'h00);
            @(negedge clk);
        end
        step = 1'b1;
        wait_done("cfg_next", 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
